// File: rtl/azadi_wb_pkg.sv
// rtl/azadi_wb_pkg.sv - shared types and constants for the Azadi Wishbone initiator
package azadi_wb_pkg;

  // Default bus geometry: byte address and data widths
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  // Read data returned when a cycle is abandoned by the timeout
  localparam logic [WB_DW-1:0] WB_ERR_DATA = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_e;

endpackage

// File: rtl/azadi_wb_master.sv
// rtl/azadi_wb_master.sv - Wishbone classic single-beat initiator; optional ack timeout under AZADI_WB_MASTER_TIMEOUT_EN
module azadi_wb_master
  import azadi_wb_pkg::*;
#(
  parameter int AW             = WB_AW,
  parameter int DW             = WB_DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  input  logic [DW/8-1:0] req_sel_i,
  output logic            rsp_valid_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i
);

  wbm_state_e state;
  wbm_state_e state_next;
  logic       accept;
  logic       timeout_hit;

  // A zero timeout would abort every cycle before the responder can answer
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
    $error("azadi_wb_master: TIMEOUT_CYCLES must be at least 1");
  end

  assign accept = (state == IDLE) && req_valid_i;

  // All handshake and strobe outputs decode directly from the state register,
  // so nothing on the bus side reaches an output combinationally.
  assign req_ready_o = (state == IDLE);
  assign wbm_cyc_o   = (state == BUS);
  assign wbm_stb_o   = (state == BUS);
  assign rsp_valid_o = (state == RESP);

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one bus cycle per request, always followed by a response beat
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (req_valid_i) state_next = BUS;
      BUS:  if (wbm_ack_i || timeout_hit) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the request into the bus-side registers; they stay put while in BUS
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
    end else if (accept) begin
      wbm_we_o  <= req_we_i;
      wbm_adr_o <= req_addr_i;
      wbm_dat_o <= req_wdata_i;
      wbm_sel_o <= req_sel_i;
    end
  end

  // Response fields update only when a cycle ends and hold until the next one;
  // ack takes priority over a timeout landing in the same cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (state == BUS) begin
      if (wbm_ack_i) begin
        rsp_rdata_o <= wbm_we_o ? '0 : wbm_dat_i;
        rsp_err_o   <= 1'b0;
      end else if (timeout_hit) begin
        rsp_rdata_o <= {DW{WB_ERR_DATA[0]}};
        rsp_err_o   <= 1'b1;
      end
    end
  end

`ifdef AZADI_WB_MASTER_TIMEOUT_EN
  localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] to_cnt;

  // Count unacknowledged BUS cycles; idle outside BUS so every cycle starts from zero
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || (state != BUS)) begin
      to_cnt <= '0;
    end else if (!wbm_ack_i) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Fires in the last permitted BUS cycle, so cyc is high exactly TIMEOUT_CYCLES cycles
  assign timeout_hit = (state == BUS) && (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_azadi_wb_master.sv
// tb/tb_azadi_wb_master.sv - directed scoreboard bench for azadi_wb_master (timeout steps under AZADI_WB_MASTER_TIMEOUT_EN)
module tb_azadi_wb_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic        ack;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  azadi_wb_master #(
    .AW(32), .DW(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel),
    .wbm_dat_i(dat_i), .wbm_ack_i(ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [32:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, " unexpected response"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " rsp_err"}, rsp_err, e[32]);
      chk({tag, " rsp_rdata"}, rsp_rdata, e[31:0]);
    end
  endtask

  // One request; waits < 0 means the responder never acks.
  task automatic run_txn(input string tag, input logic t_we, input logic [31:0] t_addr,
                         input logic [31:0] t_wdata, input logic [3:0] t_sel,
                         input int waits, input logic [31:0] rsp_word);
    int exp_cyc;
    int ncyc;
    bit got;
    bit stable_bad;
    if (waits < 0) begin
      exp_cyc = TO;
      sb_q.push_back({1'b1, 32'hFFFF_FFFF});
    end else begin
      exp_cyc = waits + 1;
      sb_q.push_back({1'b0, t_we ? 32'h0 : rsp_word});
    end
    @(negedge clk);
    chk({tag, " ready before"}, req_ready, 1);
    req_we = t_we; req_addr = t_addr; req_wdata = t_wdata; req_sel = t_sel; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_0000;
    chk({tag, " cyc first"}, cyc, 1);
    chk({tag, " stb first"}, stb, 1);
    chk({tag, " we"}, we, t_we);
    chk({tag, " adr"}, adr, t_addr);
    chk({tag, " dat_o"}, dat_o, t_wdata);
    chk({tag, " sel"}, sel, t_sel);
    ncyc = 0; got = 0; stable_bad = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      if (rsp_valid) begin
        got = 1;
        ack = 1'b0;
        chk({tag, " cyc low at rsp"}, cyc, 0);
        sb_check(tag);
      end else begin
        if (cyc) begin
          ncyc++;
          if (!stb || req_ready || adr !== t_addr || we !== t_we) stable_bad = 1;
        end
        if (cyc && waits >= 0 && ncyc == waits + 1) begin
          ack = 1'b1;
          dat_i = rsp_word;
        end else begin
          ack = 1'b0;
          dat_i = 32'h5555_AAAA;
        end
        @(negedge clk);
      end
    end
    chk({tag, " response seen"}, got, 1);
    chk({tag, " cyc length"}, ncyc, exp_cyc);
    chk({tag, " bus stable"}, stable_bad, 0);
    @(negedge clk);
    chk({tag, " rsp one cycle"}, rsp_valid, 0);
    chk({tag, " ready after"}, req_ready, 1);
  endtask

  initial begin
    int nbus;
    int nresp;
    int viol;
    bit prev_cyc;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_sel = '0; dat_i = '0; ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ready", req_ready, 1);
    chk("reset cyc", cyc, 0);
    chk("reset stb", stb, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset outs", {we, adr, dat_o, sel, rsp_rdata, rsp_err}, 0);

    run_txn("write0", 1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 32'h7777_7777);
    run_txn("read3w", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 32'hCAFE_F00D);
    chk("rdata hold", rsp_rdata, 32'hCAFE_F00D);
    run_txn("read_sel", 1'b0, 32'h3000_0022, 32'h0, 4'h3, 1, 32'h0000_BEEF);

    // Stray ack while idle
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("stray rsp_valid", rsp_valid, 0);
    chk("stray cyc", cyc, 0);
    chk("stray ready", req_ready, 1);

    // Three back-to-back requests with req_valid held high
    for (int k = 0; k < 3; k++) sb_q.push_back({1'b0, 32'h1000_0000 + 32'(k)});
    req_we = 1'b0; req_addr = 32'h3000_0100; req_sel = 4'hF; req_valid = 1'b1;
    nbus = 0; nresp = 0; viol = 0; prev_cyc = 0;
    for (int i = 0; i < 40 && nresp < 3; i++) begin
      @(negedge clk);
      if (cyc && !prev_cyc) nbus++;
      if (cyc && prev_cyc) viol++;
      ack = cyc;
      dat_i = 32'h1000_0000 + 32'(nbus - 1);
      if (rsp_valid) begin
        nresp++;
        sb_check("b2b");
        if (nresp == 3) req_valid = 1'b0;
      end
      prev_cyc = cyc;
    end
    ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cyc && !prev_cyc) nbus++;
      if (rsp_valid) nresp++;
      prev_cyc = cyc;
    end
    chk("b2b bus cycles", nbus, 3);
    chk("b2b responses", nresp, 3);
    chk("b2b idle gap", viol, 0);

`ifdef AZADI_WB_MASTER_TIMEOUT_EN
    run_txn("timeout", 1'b0, 32'h3000_0200, 32'h0, 4'hF, -1, 32'h0);
    run_txn("ack_at_limit", 1'b0, 32'h3000_0204, 32'h0, 4'hF, TO - 1, 32'h1234_5678);
`endif

    // Reset during the second wait state drops the cycle without a response
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h3000_0300; req_sel = 4'hF; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst cyc wait0", cyc, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rst cyc wait2", cyc, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst mid cyc", cyc, 0);
    chk("rst mid stb", stb, 0);
    chk("rst mid rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    nresp = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) nresp++;
    end
    chk("rst no response", nresp, 0);
    chk("rst ready", req_ready, 1);
    run_txn("read_after_rst", 1'b0, 32'h3000_0304, 32'h0, 4'hF, 2, 32'h0BAD_CAFE);

    chk("scoreboard empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
